bk_subtractor_pipe: RTL and testbench

- Pipelined, handshaked 64-bit subtractor: D = A - B, computed as A + ~B + 1 on a group-based Brent-Kung prefix carry network.
- Counterpart to the combinational Brent-Kung adder: turns operand pairs into a difference plus borrow, signed-overflow and zero flags.
- Sits between the register-read stage and the compare/branch logic; sustains one operation per clock with full backpressure.

---
 rtl/bk_pkg.sv | 37 +++
 rtl/bk_subtractor_pipe_if.sv | 32 +++
 rtl/bk_group_gp.sv | 48 ++++
 rtl/bk_subtractor_pipe.sv | 178 +++++++++++++++++
 tb/tb_bk_subtractor_pipe.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bk_pkg.sv
// bk_pkg: shared definitions for the Brent-Kung adder/subtractor family.
// Provides default geometry, the generate/propagate pair type, the prefix
// operator and geometry legality checks used at elaboration time.
package bk_pkg;

  localparam int BK_WIDTH     = 64;
  localparam int BK_GROUPSIZE = 8;
  localparam int BK_TAG_W     = 4;

  // Generate/propagate pair for a bit or a contiguous span of bits.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // (g,p)hi o (g,p)lo : hi span sits directly above lo span.
  function automatic gp_t prefix_op(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic bit groupsize_ok(int gs);
    return (gs == 1) || (gs == 2) || (gs == 4) || (gs == 8);
  endfunction

  // Group count must be a power of two of at least 4 for the tree shape used.
  function automatic bit geometry_ok(int w, int gs);
    int ng;
    if (!groupsize_ok(gs)) return 1'b0;
    if ((w % gs) != 0) return 1'b0;
    ng = w / gs;
    return (ng >= 4) && ((ng & (ng - 1)) == 0);
  endfunction

endpackage

// File: rtl/bk_subtractor_pipe_if.sv
// bk_subtractor_pipe_if: operand/result handshake bundle for the subtractor.
// Ports: in_valid/in_ready/A/B/in_tag toward the block, out_valid/out_ready/
// D/borrow/ovf/zero/out_tag from it. master = producer/consumer, slave = block.
interface bk_subtractor_pipe_if
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH,
  parameter int TAG_W = BK_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             borrow;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, A, B, in_tag, out_ready,
    input  in_ready, out_valid, D, borrow, ovf, zero, out_tag
  );

  modport slave (
    input  in_valid, A, B, in_tag, out_ready,
    output in_ready, out_valid, D, borrow, ovf, zero, out_tag
  );
endinterface

// File: rtl/bk_group_gp.sv
// bk_group_gp: one GROUPSIZE-bit slice; combinational, no state, no handshake.
// Ports: a_i/b_i operand slices (b_i already inverted for subtraction),
// cin_i group carry-in; gp_o group (G,P), sum_o slice sum, cout_o carry-out.
module bk_group_gp
  import bk_pkg::*;
#(
  parameter int GROUPSIZE = BK_GROUPSIZE
) (
  input  logic [GROUPSIZE-1:0] a_i,
  input  logic [GROUPSIZE-1:0] b_i,
  input  logic                 cin_i,
  output gp_t                  gp_o,
  output logic [GROUPSIZE-1:0] sum_o,
  output logic                 cout_o
);
  logic [GROUPSIZE-1:0] g;
  logic [GROUPSIZE-1:0] p;
  logic [GROUPSIZE:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Fold bit pairs from LSB upward into the group pair.
  always_comb begin
    gp_t acc;
    gp_t bit_gp;
    acc.g    = g[0];
    acc.p    = p[0];
    bit_gp.g = 1'b0;
    bit_gp.p = 1'b0;
    for (int k = 1; k < GROUPSIZE; k++) begin
      bit_gp.g = g[k];
      bit_gp.p = p[k];
      acc      = prefix_op(bit_gp, acc);
    end
    gp_o = acc;
  end

  always_comb begin
    c[0] = cin_i;
    for (int k = 0; k < GROUPSIZE; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
    end
  end

  assign sum_o  = p ^ c[GROUPSIZE-1:0];
  assign cout_o = c[GROUPSIZE];
endmodule

// File: rtl/bk_subtractor_pipe.sv
// bk_subtractor_pipe: D = A + ~B + 1 with borrow/ovf/zero flags and a tag.
// Latency 3 cycles; one global advance (~out_valid | out_ready) gates all
// stages, so a stalled output freezes the whole pipe and in_ready drops.
// Ports: clk, rst (async active-high), bus (slave side of the handshake).
module bk_subtractor_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH     = BK_WIDTH,
  parameter int GROUPSIZE = BK_GROUPSIZE,
  parameter int TAG_W     = BK_TAG_W
) (
  input logic                 clk,
  input logic                 rst,
  bk_subtractor_pipe_if.slave bus
);
  localparam int NG   = WIDTH / GROUPSIZE;
  localparam int LOG  = $clog2(NG);
  localparam int NLVL = 2 * LOG;  // level 0 leaves, LOG up-sweep, LOG-1 down-sweep

  if (!geometry_ok(WIDTH, GROUPSIZE)) begin : g_bad_geometry
    $error("bk_subtractor_pipe: illegal WIDTH/GROUPSIZE combination");
  end

  logic adv;

  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] nb1_q;
  logic [TAG_W-1:0] tag1_q;

  logic             v2_q;
  logic [WIDTH-1:0] a2_q;
  logic [WIDTH-1:0] nb2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [NG-1:0]    cin_d;
  logic [NG-1:0]    cin2_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] d_q;
  logic             carry_out;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  // Slice outputs not needed in a given use of bk_group_gp.
  logic [WIDTH-1:0] s1_sum_unused;
  logic [NG-1:0]    s1_cout_unused;
  gp_t              s3_gp_unused [NG];
  logic [NG-2:0]    s3_cout_unused;
  gp_t              prefix_top_unused;

  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: capture A, ~B, tag ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      nb1_q  <= '0;
      tag1_q <= '0;
    end else if (adv) begin
      v1_q   <= bus.in_valid;
      a1_q   <= bus.A;
      nb1_q  <= ~bus.B;
      tag1_q <= bus.in_tag;
    end
  end

  // ---------------- Prefix tree over group pairs ----------------
  // Each level lives in its own generate scope so no signal depends on itself.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    gp_t node [NG];
    for (genvar i = 0; i < NG; i++) begin : g_n
      if (l == 0) begin : g_leaf
        bk_group_gp #(.GROUPSIZE(GROUPSIZE)) u_gp (
          .a_i   (a1_q[i*GROUPSIZE +: GROUPSIZE]),
          .b_i   (nb1_q[i*GROUPSIZE +: GROUPSIZE]),
          .cin_i (1'b0),
          .gp_o  (node[i]),
          .sum_o (s1_sum_unused[i*GROUPSIZE +: GROUPSIZE]),
          .cout_o(s1_cout_unused[i])
        );
      end else if (l <= LOG) begin : g_up
        localparam int SPAN = 2 ** (l - 1);
        if (((i + 1) % (2 * SPAN)) == 0) begin : g_op
          assign node[i] = prefix_op(g_lvl[l-1].node[i], g_lvl[l-1].node[i-SPAN]);
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].node[i];
        end
      end else begin : g_dn
        // Fill in the odd prefixes, halving the span each level.
        localparam int SPAN = 2 ** (NLVL - 1 - l);
        if ((((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) > 2 * SPAN)) begin : g_op
          assign node[i] = prefix_op(g_lvl[l-1].node[i], g_lvl[l-1].node[i-SPAN]);
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].node[i];
        end
      end
    end
  end

  // Carry into group i+1 is G[i:0] | P[i:0] & c0, with c0 = 1 for subtraction.
  assign cin_d[0] = 1'b1;
  for (genvar i = 0; i < NG - 1; i++) begin : g_cin
    assign cin_d[i+1] = g_lvl[NLVL-1].node[i].g | g_lvl[NLVL-1].node[i].p;
  end
  // The whole-word carry comes from the S3 ripple instead.
  assign prefix_top_unused = g_lvl[NLVL-1].node[NG-1];

  // ---------------- S2: register group carry-ins ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      a2_q   <= '0;
      nb2_q  <= '0;
      tag2_q <= '0;
      cin2_q <= '0;
    end else if (adv) begin
      v2_q   <= v1_q;
      a2_q   <= a1_q;
      nb2_q  <= nb1_q;
      tag2_q <= tag1_q;
      cin2_q <= cin_d;
    end
  end

  // ---------------- S3: per-group ripple and flags ----------------
  for (genvar i = 0; i < NG; i++) begin : g_s3
    if (i == NG - 1) begin : g_top
      bk_group_gp #(.GROUPSIZE(GROUPSIZE)) u_sum (
        .a_i   (a2_q[i*GROUPSIZE +: GROUPSIZE]),
        .b_i   (nb2_q[i*GROUPSIZE +: GROUPSIZE]),
        .cin_i (cin2_q[i]),
        .gp_o  (s3_gp_unused[i]),
        .sum_o (d_d[i*GROUPSIZE +: GROUPSIZE]),
        .cout_o(carry_out)
      );
    end else begin : g_mid
      bk_group_gp #(.GROUPSIZE(GROUPSIZE)) u_sum (
        .a_i   (a2_q[i*GROUPSIZE +: GROUPSIZE]),
        .b_i   (nb2_q[i*GROUPSIZE +: GROUPSIZE]),
        .cin_i (cin2_q[i]),
        .gp_o  (s3_gp_unused[i]),
        .sum_o (d_d[i*GROUPSIZE +: GROUPSIZE]),
        .cout_o(s3_cout_unused[i])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      tag_q       <= '0;
    end else if (adv) begin
      out_valid_q <= v2_q;
      d_q         <= d_d;
      borrow_q    <= ~carry_out;
      // nb2_q holds ~B, so equal MSBs here means A and B have opposite signs.
      ovf_q       <= (a2_q[WIDTH-1] == nb2_q[WIDTH-1]) & (d_d[WIDTH-1] != a2_q[WIDTH-1]);
      zero_q      <= (d_d == '0);
      tag_q       <= tag2_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_tag   = tag_q;
endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// tb_bk_subtractor_pipe: scoreboard bench for bk_subtractor_pipe.
// Inputs change on the falling edge; handshakes are judged 1 time unit later,
// expectations pushed on accept and popped on each output transfer.
module tb_bk_subtractor_pipe;
  localparam int W  = 64;
  localparam int GS = 8;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bk_subtractor_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  bk_subtractor_pipe #(.WIDTH(W), .GROUPSIZE(GS), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] d;
    logic [2:0]  f;      // {borrow, ovf, zero}
    logic [3:0]  tag;
    int          acc_cyc;
    int          acc_stl;
  } exp_t;

  exp_t        sb[$];
  int          chk_cnt   = 0;
  int          pass_cnt  = 0;
  int          cyc       = 0;
  int          stall_cnt = 0;
  int          rdy_mode  = 0;  // 0 always ready, 1 pattern 1-0-0-1, 2 random, 3 never
  logic [3:0]  tag_ctr   = 4'd0;
  logic        prev_stall = 1'b0;
  logic [63:0] held_d;
  logic [2:0]  held_f;
  logic [3:0]  held_tag;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.d       = a - b;
    e.f[2]    = (a < b);
    e.f[1]    = (a[63] != b[63]) && (e.d[63] != a[63]);
    e.f[0]    = (e.d == 64'd0);
    e.tag     = 4'd0;
    e.acc_cyc = 0;
    e.acc_stl = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    check_val("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
    if (prev_stall) begin
      check_val("hold_vld", 64'(bus.out_valid), 64'd1);
      check_val("hold_d", bus.D, held_d);
      check_val("hold_flags", 64'({bus.borrow, bus.ovf, bus.zero}), 64'(held_f));
      check_val("hold_tag", 64'(bus.out_tag), 64'(held_tag));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_val("d", bus.D, e.d);
        check_val("flags", 64'({bus.borrow, bus.ovf, bus.zero}), 64'(e.f));
        check_val("tag", 64'(bus.out_tag), 64'(e.tag));
        if (e.acc_stl == stall_cnt) check_val("latency", 64'(cyc - e.acc_cyc), 64'd3);
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    if (prev_stall) begin
      stall_cnt++;
      held_d   = bus.D;
      held_f   = {bus.borrow, bus.ovf, bus.zero};
      held_tag = bus.out_tag;
    end
  endtask

  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] t, input logic [63:0] ed, input logic [2:0] ef,
                      output logic acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.in_tag   = t;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    #1;
    monitor();
    acc = v && bus.in_ready;
    if (acc) begin
      e.d = ed; e.f = ef; e.tag = t; e.acc_cyc = cyc; e.acc_stl = stall_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic drive_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] ed, input logic [2:0] ef);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      step(1'b1, a, b, tag_ctr, ed, ef, acc);
      n++;
    end
    if (!acc) check_val("accept_timeout", 64'(acc), 64'd1);
    tag_ctr++;
  endtask

  task automatic drive_rand(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e = model(a, b);
    drive_op(a, b, e.d, e.f);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, acc);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(1'b0, '0, '0, '0, '0, '0, acc);
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_vld", 64'(bus.out_valid), 64'd0);
    check_val("rst_d", bus.D, 64'd0);
    check_val("rst_flags", 64'({bus.borrow, bus.ovf, bus.zero}), 64'd0);
    check_val("rst_tag", 64'(bus.out_tag), 64'd0);
    rst = 1'b0;

    // Directed arithmetic, always ready
    rdy_mode = 0;
    drive_op(64'h5, 64'h3, 64'h2, 3'b000);
    drain();
    drive_op(64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100);
    drive_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 3'b001);
    drive_op(64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010);
    drive_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3'b110);
    drain();
    // Carry chain through every group, back-to-back
    drive_op(64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100);
    drive_op(64'h0100_0000_0000_0000, 64'h1, 64'h00FF_FFFF_FFFF_FFFF, 3'b000);
    // B = 0 and A == B at the extremes
    drive_op(64'hDEAD_BEEF_0123_4567, 64'h0, 64'hDEAD_BEEF_0123_4567, 3'b000);
    drive_op(64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 3'b000);
    drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b001);
    drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b000);
    drain();

    // Backpressure: tags 0..7, out_ready 1-0-0-1
    rdy_mode = 1;
    tag_ctr  = 4'd0;
    for (int i = 0; i < 8; i++) drive_rand(rnd64(), rnd64());
    drain();

    // Reset with three operations in flight
    rdy_mode = 3;
    for (int i = 0; i < 3; i++) drive_rand(rnd64(), rnd64());
    @(negedge clk);
    check_val("pre_rst_vld", 64'(bus.out_valid), 64'd1);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check_val("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_d", bus.D, 64'd0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    rdy_mode = 0;
    idle(6);
    drive_op(64'h10, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 3'b100);
    drain();

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        a = rnd64();
        b = ($urandom_range(0, 9) == 0) ? a : rnd64();
        drive_rand(a, b);
      end
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
